// File: rtl/sort_pkg.sv
// Shared widths, word format and state encoding for the sorter front-end.
package sort_pkg;

  localparam int SORT_DATA_W    = 8;
  localparam int SORT_IDX_W     = 4;
  localparam int SORT_FRAME_LEN = 12;

  typedef struct packed {
    logic [SORT_DATA_W-1:0] value;
    logic [SORT_IDX_W-1:0]  index;
  } sort_word_t;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    GAP
  } feed_state_t;

endpackage

// File: rtl/sort_feeder_fifo.sv
// Sample buffer for the frame feeder: single-clock FIFO with occupancy count.
module sort_feeder_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (count < CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sort_frame_feeder.sv
// Buffers samples and bursts full frames of {value, index} words into the sorter.
// Define SORT_FEEDER_FLUSH_EN to let FlushReq emit a zero-padded partial frame.
//   state | meaning
//   IDLE  | sorter held in clear, waiting for a frame's worth of samples
//   BURST | one frame word per cycle, index 0..FRAME_LEN-1
//   GAP   | sorter held in clear for GAP_CYCLES before the next frame
module sort_frame_feeder
  import sort_pkg::*;
#(
  parameter int DATA_W     = SORT_DATA_W,
  parameter int IDX_W      = SORT_IDX_W,
  parameter int FRAME_LEN  = SORT_FRAME_LEN,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    InValid,
  input  logic [DATA_W-1:0]       InData,
  output logic                    InReady,
  input  logic                    FlushReq,
  output logic [DATA_W+IDX_W-1:0] OutData,
  output logic                    OutValid,
  output logic                    OutSortClr,
  output logic                    FrameStart,
  output logic                    FrameEnd
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int RL_W  = $clog2(FRAME_LEN + 1);

  feed_state_t       state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_nxt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [RL_W-1:0]   real_left;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] head;
  logic [DATA_W-1:0] word_val;
  logic              frame_rdy;
  logic              flush_go;
  logic              start;
  logic              last;
  logic              pop;

  assign InReady = (count < CNT_W'(FIFO_DEPTH));

  sort_feeder_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (Reset_n),
    .push  (InValid && InReady),
    .pop   (pop),
    .wdata (InData),
    .rdata (head),
    .count (count)
  );

`ifdef SORT_FEEDER_FLUSH_EN
  assign flush_go = FlushReq && (count != '0) && !frame_rdy;
`else
  logic flush_unused;
  assign flush_unused = FlushReq;
  assign flush_go     = 1'b0;
`endif

  assign frame_rdy = (count >= CNT_W'(FRAME_LEN));
  assign last      = (idx == IDX_W'(FRAME_LEN - 1));
  assign idx_nxt   = idx + 1'b1;
  // Once the buffered samples of a flushed frame run out, the tail is padded with zeros.
  assign word_val  = (real_left != '0) ? head : '0;

  always_comb begin
    start = 1'b0;
    case (state)
      IDLE:    start = frame_rdy || flush_go;
      GAP:     start = (gap_cnt == '0) && frame_rdy;
      default: start = 1'b0;
    endcase
    pop = start || ((state == BURST) && !last && (real_left != '0));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      idx        <= '0;
      gap_cnt    <= '0;
      real_left  <= '0;
      OutData    <= '0;
      OutValid   <= 1'b0;
      OutSortClr <= 1'b1;
      FrameStart <= 1'b0;
      FrameEnd   <= 1'b0;
    end else begin
      FrameStart <= 1'b0;
      FrameEnd   <= 1'b0;
      if (start) begin
        state      <= BURST;
        idx        <= '0;
        real_left  <= frame_rdy ? RL_W'(FRAME_LEN - 1) : RL_W'(count - 1'b1);
        OutData    <= {head, IDX_W'(0)};
        OutValid   <= 1'b1;
        OutSortClr <= 1'b0;
        FrameStart <= 1'b1;
        FrameEnd   <= (FRAME_LEN == 1);
      end else begin
        case (state)
          BURST: begin
            if (last) begin
              state      <= GAP;
              gap_cnt    <= GAP_W'(GAP_CYCLES - 1);
              OutData    <= '0;
              OutValid   <= 1'b0;
              OutSortClr <= 1'b1;
            end else begin
              idx      <= idx_nxt;
              OutData  <= {word_val, idx_nxt};
              FrameEnd <= (idx_nxt == IDX_W'(FRAME_LEN - 1));
              if (real_left != '0) real_left <= real_left - 1'b1;
            end
          end
          GAP: begin
            if (gap_cnt == '0) state <= IDLE;
            else               gap_cnt <= gap_cnt - 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sort_frame_feeder.sv
// Randomized and directed bench for sort_frame_feeder against a slot-schedule model.
`timescale 1ns/1ps
module tb_sort_frame_feeder;
  import sort_pkg::*;

  localparam int DW = 8;
  localparam int IW = 4;
  localparam int FL = 12;
  localparam int FD = 16;
  localparam int GC = 2;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b1;
  logic          InValid = 1'b0;
  logic [DW-1:0] InData = '0;
  logic          FlushReq = 1'b0;
  logic          InReady;
  logic [DW+IW-1:0] OutData;
  logic          OutValid;
  logic          OutSortClr;
  logic          FrameStart;
  logic          FrameEnd;

  sort_frame_feeder #(
    .DATA_W(DW), .IDX_W(IW), .FRAME_LEN(FL), .FIFO_DEPTH(FD), .GAP_CYCLES(GC)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .InValid(InValid), .InData(InData),
    .InReady(InReady), .FlushReq(FlushReq), .OutData(OutData),
    .OutValid(OutValid), .OutSortClr(OutSortClr),
    .FrameStart(FrameStart), .FrameEnd(FrameEnd)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: a frame is a schedule of FL word slots then GC clear slots, started
  // whenever the schedule is empty and enough samples are buffered.
  typedef struct {
    bit gap;
    bit real_w;
    int idx;
  } slot_t;

  int    q[$];
  slot_t plan[$];
  bit    gap_tail = 0;
  logic  e_valid = 0, e_start = 0, e_end = 0, e_clr = 1;
  logic [DW+IW-1:0] e_data = '0;
  int    m_cnt, m_n, m_v;
  slot_t m_s;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      q.delete();
      plan.delete();
      gap_tail = 0;
      e_valid = 0; e_start = 0; e_end = 0; e_clr = 1; e_data = '0;
    end else begin
      m_cnt = q.size();
      if (plan.size() == 0) begin
        m_n = 0;
        if (m_cnt >= FL) m_n = FL;
`ifdef SORT_FEEDER_FLUSH_EN
        else if (FlushReq && m_cnt > 0 && !gap_tail) m_n = m_cnt;
`endif
        if (m_n > 0) begin
          for (int i = 0; i < FL; i++) begin
            m_s.gap = 0; m_s.real_w = (i < m_n); m_s.idx = i;
            plan.push_back(m_s);
          end
          for (int g = 0; g < GC; g++) begin
            m_s.gap = 1; m_s.real_w = 0; m_s.idx = 0;
            plan.push_back(m_s);
          end
        end
      end
      gap_tail = 0;
      if (plan.size() > 0) begin
        m_s = plan.pop_front();
        if (m_s.gap) begin
          e_valid = 0; e_start = 0; e_end = 0; e_clr = 1;
          if (plan.size() == 0) gap_tail = 1;
        end else begin
          m_v = m_s.real_w ? q.pop_front() : 0;
          e_valid = 1;
          e_data  = {m_v[DW-1:0], m_s.idx[IW-1:0]};
          e_start = (m_s.idx == 0);
          e_end   = (m_s.idx == FL - 1);
          e_clr   = 0;
        end
      end else begin
        e_valid = 0; e_start = 0; e_end = 0; e_clr = 1;
      end
      if (InValid && m_cnt < FD) q.push_back(int'(InData));
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("out_valid", OutValid, e_valid);
      chk("sort_clr", OutSortClr, e_clr);
      chk("frame_start", FrameStart, e_start);
      chk("frame_end", FrameEnd, e_end);
      chk("in_ready", InReady, (q.size() < FD));
      if (e_valid) chk("out_data", OutData, e_data);
    end
  end

  // Observed-stream capture for the literal checks.
  logic [DW+IW+1:0] got[$];
  int gaps[$];
  int run = 0;
  bit seen_end = 0;
  int full_seen = 0;

  always @(negedge Clk) begin
    if (OutValid) begin
      got.push_back({FrameStart, FrameEnd, OutData});
      if (FrameStart && seen_end) gaps.push_back(run);
      if (FrameEnd) begin seen_end = 1; run = 0; end
      else if (FrameStart) seen_end = 0;
    end else if (OutSortClr) run++;
    if (!InReady) full_seen++;
  end

  task automatic clear_capture();
    got.delete(); gaps.delete(); run = 0; seen_end = 0; full_seen = 0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #2 Reset_n = 0;
    InValid = 0; FlushReq = 0;
    repeat (2) @(negedge Clk);
    #2 Reset_n = 1;
    @(negedge Clk);
    clear_capture();
  endtask

  // Called at a negedge; returns at the negedge after the sample is accepted.
  task automatic push1(input int v);
    int tries;
    tries = 0;
    InValid = 1;
    InData  = v[DW-1:0];
    forever begin
      if (InReady) begin
        @(negedge Clk);
        break;
      end
      @(negedge Clk);
      tries++;
      if (tries > 100) begin
        chk("push_timeout", 0, 1);
        break;
      end
    end
  endtask

  int vals1[FL] = '{246, 64, 234, 82, 104, 151, 141, 229, 198, 142, 140, 123};
  int fl_vals[3] = '{5, 9, 3};
  int wait_n;
  bit hit;

  initial begin
    #1 Reset_n = 0;
    repeat (2) @(negedge Clk);
    chk("rst_valid", OutValid, 0);
    chk("rst_clr", OutSortClr, 1);
    chk("rst_data", OutData, 0);
    chk("rst_ready", InReady, 1);
    #2 Reset_n = 1;
    @(negedge Clk);
    chk_en = 1;
    clear_capture();

    // Single frame of fixed samples.
    for (int i = 0; i < FL; i++) push1(vals1[i]);
    InValid = 0;
    repeat (25) @(negedge Clk);
    chk("t1_words", got.size(), FL);
    if (got.size() == FL) begin
      for (int i = 0; i < FL; i++) chk("t1_word", got[i][DW+IW-1:0], vals1[i] * 16 + i);
      chk("t1_start", got[0][DW+IW+1], 1);
      chk("t1_end", got[FL-1][DW+IW], 1);
    end

    // Two frames back to back.
    do_reset();
    for (int i = 0; i < 2 * FL; i++) push1(int'($urandom_range(1, 255)));
    InValid = 0;
    repeat (40) @(negedge Clk);
    chk("t3_words", got.size(), 2 * FL);
    chk("t3_gaps", gaps.size(), 1);
    if (gaps.size() == 1) chk("t3_gap_len", gaps[0], GC);
    if (got.size() == 2 * FL) begin
      chk("t3_idx_restart", got[FL][IW-1:0], 0);
      chk("t3_start2", got[FL][DW+IW+1], 1);
    end

    // Continuous input until the buffer fills during a gap.
    do_reset();
    for (int i = 0; i < 44; i++) push1(int'($urandom_range(0, 255)));
    InValid = 0;
    repeat (40) @(negedge Clk);
    chk("t2_full_seen", (full_seen > 0), 1);

    // Reset in the middle of a burst.
    do_reset();
    for (int i = 0; i < FL; i++) push1(int'($urandom_range(0, 255)));
    InValid = 0;
    hit = 0;
    for (wait_n = 0; wait_n < 50; wait_n++) begin
      if (OutValid && OutData[IW-1:0] == 4) begin hit = 1; break; end
      @(negedge Clk);
    end
    chk("t4_reached_word4", hit, 1);
    #2 Reset_n = 0;
    #1;
    chk("t4_async_valid", OutValid, 0);
    chk("t4_async_clr", OutSortClr, 1);
    chk("t4_async_data", OutData, 0);
    chk("t4_async_start_end", {FrameStart, FrameEnd}, 0);
    chk("t4_async_ready", InReady, 1);
    repeat (2) @(negedge Clk);
    #2 Reset_n = 1;
    @(negedge Clk);
    clear_capture();
    repeat (20) @(negedge Clk);
    chk("t4_no_stale", got.size(), 0);

    // Partial frame flush.
    do_reset();
    for (int i = 0; i < 3; i++) push1(fl_vals[i]);
    InValid = 0;
    FlushReq = 1;
    @(negedge Clk);
    FlushReq = 0;
    repeat (30) @(negedge Clk);
`ifdef SORT_FEEDER_FLUSH_EN
    chk("t5_words", got.size(), FL);
    if (got.size() == FL) begin
      for (int i = 0; i < FL; i++)
        chk("t5_word", got[i][DW+IW-1:0], (i < 3 ? fl_vals[i] * 16 : 0) + i);
      chk("t5_end", got[FL-1][DW+IW], 1);
    end
`else
    chk("t5_no_output", got.size(), 0);
`endif

    // Random traffic with occasional flush pulses; pointer wrap under push+pop.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      InValid  = ($urandom_range(0, 99) < 70);
      InData   = DW'($urandom_range(0, 255));
      FlushReq = ($urandom_range(0, 99) < 2);
      @(negedge Clk);
    end
    InValid = 0;
    FlushReq = 0;
    repeat (40) @(negedge Clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sort_frame_feeder.md
Name: sort_frame_feeder

Overview:
Upstream stage of the sequential sorter. Accepts raw 8-bit samples over a valid/ready handshake and buffers them in a FIFO. Once a full frame is buffered, it emits the frame as a back-to-back burst of {value, index} words, one per cycle, in the 12-bit format the sorter's DataIn expects. It holds the sorter in clear between frames.

Parameters:
DATA_W, 8, sample value width (OutData[DATA_W+IDX_W-1:IDX_W])
IDX_W, 4, index width (OutData[IDX_W-1:0])
FRAME_LEN, 12, samples per frame; must be ≤ 2^IDX_W
FIFO_DEPTH, 16, buffer entries; must be ≥ FRAME_LEN and a power of 2
GAP_CYCLES, 2, clear cycles between frames; must be ≥ 1

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  asynchronous, active-low reset
InValid  in  1  upstream sample valid
InData  in  DATA_W  upstream sample
InReady  out  1  feeder can accept a sample
FlushReq  in  1  single-cycle pulse: emit the partial frame (optional feature)
OutData  out  DATA_W+IDX_W  {value, index} to sorter DataIn
OutValid  out  1  OutData holds a frame word
OutSortClr  out  1  sorter clear/reset request
FrameStart  out  1  high with index 0 word
FrameEnd  out  1  high with index FRAME_LEN-1 word

Behaviour:
- Reset (Reset_n low, asynchronous): FIFO is emptied (rd/wr pointers and count = 0) and state = IDLE. Outputs: OutData=0, OutValid=0, FrameStart=0, FrameEnd=0, OutSortClr=1.
- InReady = (count < FIFO_DEPTH), combinational from the registered count. A push on the same cycle as a pop does not raise InReady when the FIFO is full.
- Push occurs when InValid && InReady at the clock edge. A push updates count at the same edge.
- All outputs except InReady are registered.
- FSM states:
  - IDLE: OutSortClr=1, OutValid=0. If count ≥ FRAME_LEN at the edge, go to BURST, pop the head, and drive OutData={head,0}, OutValid=1, FrameStart=1.
  - BURST: each edge pops the next word and increments the index. At the edge that presents index FRAME_LEN-1, FrameEnd=1. At the next edge, go to GAP with OutValid=0 and OutSortClr=1. No stalls occur mid-burst; the data is guaranteed present by the entry condition.
  - GAP: hold for GAP_CYCLES cycles with OutSortClr=1, then go to IDLE. If count ≥ FRAME_LEN at the last GAP edge, go directly to BURST; the minimum inter-frame spacing is GAP_CYCLES.
- Index always restarts at 0 each frame and never wraps mid-frame.
- Latency: the sample completing a frame is accepted at edge N. In IDLE, the first OutValid is at edge N+1.
- Simultaneous push and pop: count is unchanged and the pointers both advance, wrapping modulo FIFO_DEPTH.
- Reset mid-burst: the partial frame is discarded and OutSortClr=1 immediately (asynchronous).

Optional Feature:
- Macro: SORT_FEEDER_FLUSH_EN.
- Enabled: a FlushReq pulse in IDLE with 0 < count < FRAME_LEN is latched. The feeder starts a BURST that emits the count buffered samples. The remaining indices are emitted with value 0 (pad) and OutValid=1, so the frame still has FRAME_LEN words.
- Pad words are 8'd0, so they sort to the bottom.
- FlushReq outside IDLE, or with count=0, is ignored.
- Disabled: the FlushReq port is present but ignored, and partial frames wait indefinitely.

Decomposition:
- Package sort_pkg holds DATA_W, IDX_W and FRAME_LEN defaults, a packed struct typedef sort_word_t {value, index}, and the FSM state enum {IDLE, BURST, GAP}.
- One sub-module, sort_feeder_fifo: a synchronous FIFO with count output and push/pop inputs, using the same asynchronous active-low reset.

Test Plan:
1. Reset, then push 246,64,234,82,104,151,141,229,198,142,140,123 on consecutive cycles → one cycle after the 12th push, 12 consecutive OutValid words {246,0}…{123,11}. FrameStart is high on the first word and FrameEnd on the last. OutSortClr is 0 during the burst and 1 for the following 2 cycles.
2. Push 16 samples with no frame drained (hold for test by stalling with 15 then 1 more during GAP) → InReady=0 when count=16, and a 17th InValid is not accepted. After the pop, InReady returns to 1.
3. Push 24 samples back-to-back → two bursts separated by exactly GAP_CYCLES=2 cycles of OutSortClr=1. The second frame's indices restart at 0.
4. Assert Reset_n low at the 5th word of a burst → outputs go to reset values asynchronously. After release, the FIFO is empty and no stale words appear.
5. With SORT_FEEDER_FLUSH_EN: push 5,9,3, then pulse FlushReq → the burst emits {5,0},{9,1},{3,2} followed by {0,3}…{0,11}. Without the macro → no OutValid.
6. Push and pop on the same cycle at count=12 during a burst → count stays constant, and wrap-around of the pointers past entry 15 preserves sample order.
